// File: rtl/song_pkg.sv
// rtl/song_pkg.sv - shared types, constants and LFSR step for the song generator
package song_pkg;

    localparam int NOTE_W   = 3;
    localparam int NIBBLE_W = 4;
    localparam int NOTES    = 8;

    // Right-shifting Fibonacci LFSR, taps 16,14,13,11 -> state bits 0,2,3,5 feed bit 15
    localparam logic [15:0] LFSR_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_WRITE,
        ST_START,
        ST_WAIT_END
    } state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/song_lfsr.sv
// rtl/song_lfsr.sv - free-running 16-bit Fibonacci LFSR used as the note source
module song_lfsr
    import song_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;

    // Step every cycle regardless of the FSM so user timing perturbs the sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/song_gen.sv
// rtl/song_gen.sv - random 8-note song generator and game handshake FSM (option: SONG_GEN_NO_REPEAT_EN)
module song_gen
    import song_pkg::*;
#(
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          NOTES = song_pkg::NOTES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game,
    input  logic        game_end,
    output logic [31:0] data_in,
    output logic        write_enable,
    output logic        game_start,
    output logic        busy,
    output logic [7:0]  song_count
);

    state_e             state_q;
    logic [2:0]         idx_q;
    logic [31:0]        data_q;
    logic               we_q;
    logic               gs_q;
    logic               busy_q;
    logic [7:0]         count_q;
    logic [15:0]        lfsr_w;
    logic [NOTE_W-1:0]  cand_d;
    logic               accept_d;
    logic               lfsr_unused;

    song_lfsr u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .out   (lfsr_w)
    );

    assign cand_d      = lfsr_w[NOTE_W-1:0];
    assign lfsr_unused = ^lfsr_w[15:NOTE_W];

`ifdef SONG_GEN_NO_REPEAT_EN
    logic [NOTE_W-1:0]  prev_q;

    // Silence is never a note; the first note has no predecessor to collide with
    assign accept_d = (cand_d != '0) && ((idx_q == 3'd0) || (cand_d != prev_q));

    // Remember the last accepted note for the repeat filter
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else if (state_q == ST_GEN && accept_d) begin
            prev_q <= cand_d;
        end
    end
`else
    // Silence is never a note; repeats are allowed
    assign accept_d = (cand_d != '0);
`endif

    // Main FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            data_q  <= 32'd0;
            we_q    <= 1'b0;
            gs_q    <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (new_game) begin
                        state_q <= ST_GEN;
                        idx_q   <= 3'd0;
                        data_q  <= 32'd0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_GEN: begin
                    if (accept_d) begin
                        data_q[{idx_q, 2'b00} +: NOTE_W] <= cand_d;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'(NOTES - 1)) begin
                            state_q <= ST_WRITE;
                            we_q    <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    we_q    <= 1'b0;
                    gs_q    <= 1'b1;
                    state_q <= ST_START;
                end
                ST_START: begin
                    gs_q    <= 1'b0;
                    state_q <= ST_WAIT_END;
                end
                ST_WAIT_END: begin
                    if (game_end) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        count_q <= count_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    we_q    <= 1'b0;
                    gs_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_in      = data_q;
    assign write_enable = we_q;
    assign game_start   = gs_q;
    assign busy         = busy_q;
    assign song_count   = count_q;

endmodule

// File: tb/tb_song_gen.sv
// tb/tb_song_gen.sv - self-checking bench for song_gen
module tb_song_gen;

    logic        clk;
    logic        reset;
    logic        new_game;
    logic        game_end;
    logic [31:0] data_in;
    logic        write_enable;
    logic        game_start;
    logic        busy;
    logic [7:0]  song_count;

    int checks   = 0;
    int failures = 0;

    song_gen dut (
        .clk          (clk),
        .reset        (reset),
        .new_game     (new_game),
        .game_end     (game_end),
        .data_in      (data_in),
        .write_enable (write_enable),
        .game_start   (game_start),
        .busy         (busy),
        .song_count   (song_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference LFSR: integer shift/xor form of the taps 16,14,13,11 sequence
    function automatic int ref_step(input int l);
        int b;
        b = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return ((l >> 1) | (b << 15)) & 16'hFFFF;
    endfunction

    int m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= ref_step(m_lfsr);
    end

    // Predict the song and the number of GEN cycles from the LFSR value in the first GEN cycle
    task automatic predict(input int l0, output logic [31:0] song, output int cyc);
        int l;
        int n;
        int c;
        int prev;
        bit ok;
        l = l0; n = 0; cyc = 0; prev = -1; song = 32'd0;
        while (n < 8) begin
            c = l % 8;
            cyc++;
            ok = (c != 0);
`ifdef SONG_GEN_NO_REPEAT_EN
            if (c == prev) ok = 1'b0;
`endif
            if (ok) begin
                song = song | (32'(c) << (4 * n));
                prev = c;
                n++;
            end
            l = ref_step(l);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ng;
        logic        ge;
        logic        exp_busy;
        logic        exp_we;
        logic        exp_gs;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];
    int   m_count = 0;
    bit   saw_repeat = 0;

    // One full game: idle gap, song generation, strobes, wait, game end
    task automatic run_game(input int ng_delay, input int ge_delay, input bit hold_ng);
        logic [31:0] exp_song;
        int          exp_cyc;
        int          gen;
        int          we_cnt;
        for (int i = 0; i < ng_delay; i++) begin
            chk("idle_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        new_game = 1'b1;
        @(negedge clk);
        if (!hold_ng) new_game = 1'b0;
        predict(m_lfsr, exp_song, exp_cyc);
        chk("gen_entry_busy", 32'(busy), 32'd1);
        chk("gen_entry_data", data_in, 32'd0);
        gen = 0;
        we_cnt = 0;
        while (write_enable !== 1'b1 && gen < 200) begin
            gen++;
            if (game_start !== 1'b0) chk("gen_no_start", 32'(game_start), 32'd0);
            @(negedge clk);
        end
        chk("gen_cycles", gen, exp_cyc);
        chk("we_high", 32'(write_enable), 32'd1);
        chk("we_gs_exclusive", 32'(game_start), 32'd0);
        chk("song_data", data_in, exp_song);
        chk("bit3_zero", data_in & 32'h8888_8888, 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (data_in[4*k +: 3] == 3'd0) chk("note_nonzero", 32'(k), 32'hFF);
            if (k > 0 && data_in[4*k +: 3] == data_in[4*(k-1) +: 3]) begin
                saw_repeat = 1'b1;
`ifdef SONG_GEN_NO_REPEAT_EN
                chk("no_repeat", data_in, exp_song ^ 32'hFFFF_FFFF);
`endif
            end
        end
        @(negedge clk);
        chk("we_one_cycle", 32'(write_enable), 32'd0);
        chk("gs_high", 32'(game_start), 32'd1);
        chk("data_stable_start", data_in, exp_song);
        new_game = 1'b0;
        @(negedge clk);
        chk("gs_one_cycle", 32'(game_start), 32'd0);
        chk("wait_busy", 32'(busy), 32'd1);
        for (int i = 0; i < ge_delay; i++) begin
            if (write_enable) we_cnt++;
            @(negedge clk);
            chk("wait_hold_busy", 32'(busy), 32'd1);
        end
        chk("wait_no_extra_we", 32'(we_cnt), 32'd0);
        chk("data_stable_wait", data_in, exp_song);
        game_end = 1'b1;
        @(negedge clk);
        game_end = 1'b0;
        m_count = (m_count + 1) % 256;
        chk("end_busy_drop", 32'(busy), 32'd0);
        chk("song_count", 32'(song_count), 32'(m_count));
        chk("data_stable_idle", data_in, exp_song);
    endtask

    initial begin
        int k;
        reset = 1'b1;
        new_game = 1'b0;
        game_end = 1'b0;

        //            rst   ng    ge    busy  we    gs    data
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};

        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            reset = vecs[i].rst;
            new_game = vecs[i].ng;
            game_end = vecs[i].ge;
            @(negedge clk);
            chk("vec_busy", 32'(busy), 32'(vecs[i].exp_busy));
            chk("vec_we", 32'(write_enable), 32'(vecs[i].exp_we));
            chk("vec_gs", 32'(game_start), 32'(vecs[i].exp_gs));
            chk("vec_data", data_in, vecs[i].exp_data);
            chk("vec_count", 32'(song_count), 32'd0);
        end
        reset = 1'b0;
        new_game = 1'b0;
        game_end = 1'b0;

        // Quiet idle: nothing may move
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy || write_enable || game_start || data_in != 0 || song_count != 0)
                chk("idle20", {data_in[23:0], song_count}, 32'd0);
        end
        chk("idle20_busy", 32'(busy), 32'd0);
        chk("idle20_count", 32'(song_count), 32'd0);

        // new_game held high through the whole song: one write_enable, no restart
        run_game(2, 0, 1'b1);
        run_game(0, 3, 1'b0);

        // Reset in GEN with four notes written
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        k = 0;
        while (data_in[15:12] == 4'd0 && k < 100) begin
            k++;
            @(negedge clk);
        end
        chk("mid_gen_reached", 32'(k < 100), 32'd1);
        chk("mid_gen_idx4", 32'(data_in[19:16]), 32'd0);
        chk("mid_gen_still_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_count = 0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_data", data_in, 32'd0);
        chk("rst_mid_count", 32'(song_count), 32'd0);
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (write_enable || game_start || busy) k++;
            @(negedge clk);
        end
        chk("rst_mid_no_strobe", 32'(k), 32'd0);

        // Many randomized games; covers song_count wrap and repeat statistics
        for (int g = 0; g < 1000; g++) begin
            run_game(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end
`ifndef SONG_GEN_NO_REPEAT_EN
        chk("repeat_seen", 32'(saw_repeat), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/song_gen.md
SONG_GEN -- requirements
Module: song_gen

Interface
REQ-001 Parameter SEED, default 16'hACE1, is the LFSR reset value and SHALL be nonzero.
REQ-002 Parameter NOTES, default 8, is the number of notes per song (fixed 8 this revision).
REQ-003 Port clk, input, 1, is the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-005 Port new_game, input, 1: a level sampled each cycle; it requests a new song.
REQ-006 Port game_end, input, 1: level from the game block meaning the game is finished.
REQ-007 Port data_in, output, 32: the packed song; nibble i holds note i in bits [2:0], and bit 3 of every nibble SHALL be 0.
REQ-008 Port write_enable, output, 1: a one-cycle strobe meaning data_in is valid for loading.
REQ-009 Port game_start, output, 1: a one-cycle strobe that starts play.
REQ-010 Port busy, output, 1: high in every state except IDLE.
REQ-011 Port song_count, output, 8: the number of completed games.

Function
REQ-012 FSM states SHALL be IDLE, GEN, WRITE, START and WAIT_END, all registered.
REQ-013 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL step every cycle in every state, so that user timing adds entropy.
REQ-014 IDLE -> GEN SHALL occur on new_game=1; new_game SHALL be ignored in all other states.
REQ-015 On entering GEN, note index idx SHALL be 0 and data_in SHALL be cleared to 0.
REQ-016 In GEN, each cycle the candidate note SHALL be lfsr[2:0]; a value of 0 (silence) SHALL be rejected; otherwise it SHALL be written to nibble idx and idx SHALL increment.
REQ-017 GEN -> WRITE SHALL occur in the cycle after the 8th accepted note; GEN therefore lasts at least 8 cycles.
REQ-018 In WRITE, write_enable SHALL be 1 for exactly one cycle; the next state SHALL be START.
REQ-019 In START, game_start SHALL be 1 for exactly one cycle, strictly after write_enable; the next state SHALL be WAIT_END.
REQ-020 data_in SHALL remain stable from WRITE until the next entry into GEN.
REQ-021 WAIT_END -> IDLE SHALL occur on game_end=1; song_count SHALL increment in that transition and wrap from 255 to 0.
REQ-022 If game_end=1 already holds in the first WAIT_END cycle, the block SHALL still return to IDLE.
REQ-023 write_enable and game_start SHALL never be high in the same cycle.

Reset
REQ-024 reset=1 SHALL override all other inputs in the same cycle.
REQ-025 Reset values: state IDLE, lfsr SEED, idx 0, data_in 0, write_enable 0, game_start 0, busy 0, song_count 0.
REQ-026 Reset during any state, including GEN mid-song, SHALL abandon the song with no strobe issued.

Configuration
REQ-027 Macro SONG_GEN_NO_REPEAT_EN SHALL select repeat handling.
REQ-028 With the macro defined, a candidate equal to the previously accepted note SHALL also be rejected; idx 0 SHALL have no predecessor.
REQ-029 With the macro undefined, consecutive equal notes SHALL be permitted.

Structure
REQ-030 Package song_pkg SHALL hold the state enum, NOTE_W=3, NIBBLE_W=4, NOTES=8, LFSR_TAPS and DEFAULT_SEED.
REQ-031 Sub-module song_lfsr SHALL contain the LFSR (clk, reset, seed, out[15:0]); song_gen SHALL instantiate it once.

Verification
REQ-032 Reset, then idle 20 cycles -> busy=0, write_enable=0, game_start=0, data_in=0, song_count=0.
REQ-033 new_game pulse -> at least 8 GEN cycles; write_enable for 1 cycle; game_start 1 cycle later; every nibble in 1..7 with bit3=0.
REQ-034 new_game=1 held through GEN/WRITE/START -> no restart and exactly one write_enable.
REQ-035 game_end=1 in WAIT_END, repeated 256 games -> song_count wraps 255 -> 0; busy drops the cycle after game_end.
REQ-036 reset asserted with idx=4 in GEN -> next cycle state IDLE, data_in=0, no strobe afterward.
REQ-037 With SONG_GEN_NO_REPEAT_EN, run 1000 songs -> no adjacent nibbles equal; without it, at least one repeat is observed.
